// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage, one funct3 op at a time.
// Latency: 34 cycles from start to EX/MEM capture (32 BUSY iterations + DONE + HOLD), plus one per Block cycle.
// Backpressure: ctrl Block freezes BUSY and HOLD, Bubble flushes to IDLE; ex_block_flag_o stalls the pipeline.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   ctrl_signal_muldiv_i     controller command (Default / Block / Bubble / Branch)
//   muldiv_valid_i           ID/EX holds an M-extension op
//   muldiv_op_i              funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   muldiv_src1_i/_src2_i    rs1 / rs2 values
//   muldiv_result_o          result, valid in DONE and HOLD, held until the next op finishes
//   ex_block_flag_o          combinational stall request (IDLE with valid, or BUSY)
//   muldiv_ready_o           one-cycle completion pulse (DONE)
module muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      ctrl_signal_muldiv_i,
    input  logic            muldiv_valid_i,
    input  logic [2:0]      muldiv_op_i,
    input  logic [XLEN-1:0] muldiv_src1_i,
    input  logic [XLEN-1:0] muldiv_src2_i,
    output logic [XLEN-1:0] muldiv_result_o,
    output logic            ex_block_flag_o,
    output logic            muldiv_ready_o
);

    localparam int DW = 2 * XLEN;

    // Controller command encoding, shared with the pipeline controller.
    localparam logic [1:0] CTRL_STATE_DEFAULT = 2'd0;
    localparam logic [1:0] CTRL_STATE_BLOCK   = 2'd1;
    localparam logic [1:0] CTRL_STATE_BUBBLE  = 2'd2;
    localparam logic [1:0] CTRL_STATE_BRANCH  = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [4:0]      LAST_ITER = 5'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE       = {{(XLEN-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]      state_q,  state_d;
    logic [4:0]      cnt_q,    cnt_d;
    logic [2:0]      op_q,     op_d;
    logic [DW-1:0]   acc_q,    acc_d;     // product, or remainder in the upper half
    logic [XLEN-1:0] a_q,      a_d;       // multiplier magnitude / dividend->quotient
    logic [XLEN-1:0] b_q,      b_d;       // multiplicand / divisor magnitude
    logic [XLEN-1:0] src1_q,   src1_d;    // raw rs1 for REM-by-zero and overflow detect
    logic            s1neg_q,  s1neg_d;
    logic            s2neg_q,  s2neg_d;
    logic [XLEN-1:0] result_q, result_d;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic ctrl_block;
    logic ctrl_bubble;
    logic ctrl_run;

    assign ctrl_block  = (ctrl_signal_muldiv_i == CTRL_STATE_BLOCK);
    assign ctrl_bubble = (ctrl_signal_muldiv_i == CTRL_STATE_BUBBLE);
    // Branch carries no meaning for this unit and runs like Default.
    assign ctrl_run    = (ctrl_signal_muldiv_i == CTRL_STATE_DEFAULT) ||
                         (ctrl_signal_muldiv_i == CTRL_STATE_BRANCH);

    // ------------------------------------------------------------------
    // Operand preparation at start: signedness per operand and magnitudes
    // ------------------------------------------------------------------
    logic            sgn1_in;
    logic            sgn2_in;
    logic            neg1_in;
    logic            neg2_in;
    logic [XLEN-1:0] mag1_in;
    logic [XLEN-1:0] mag2_in;

    assign sgn1_in = (muldiv_op_i == OP_MULH) || (muldiv_op_i == OP_MULHSU) ||
                     (muldiv_op_i == OP_DIV)  || (muldiv_op_i == OP_REM);
    assign sgn2_in = (muldiv_op_i == OP_MULH) || (muldiv_op_i == OP_DIV) ||
                     (muldiv_op_i == OP_REM);
    assign neg1_in = sgn1_in && muldiv_src1_i[XLEN-1];
    assign neg2_in = sgn2_in && muldiv_src2_i[XLEN-1];
    assign mag1_in = neg1_in ? ({XLEN{1'b0}} - muldiv_src1_i) : muldiv_src1_i;
    assign mag2_in = neg2_in ? ({XLEN{1'b0}} - muldiv_src2_i) : muldiv_src2_i;

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply
    // The accumulator shifts right while partial sums enter at the top, so
    // after XLEN steps it holds the full product without a wide shifter.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mul_addend;
    logic [XLEN:0]   mul_sum;
    logic [DW-1:0]   mul_acc_nx;
    logic [XLEN-1:0] mul_a_nx;

    assign mul_addend = a_q[0] ? b_q : {XLEN{1'b0}};
    assign mul_sum    = {1'b0, acc_q[DW-1:XLEN]} + {1'b0, mul_addend};
    assign mul_acc_nx = {mul_sum, acc_q[XLEN-1:1]};
    assign mul_a_nx   = {1'b0, a_q[XLEN-1:1]};

    // ------------------------------------------------------------------
    // One iteration of restoring divide
    // The partial remainder is always below the divisor, so it fits in XLEN
    // bits; only the shifted-in value needs the extra bit for the compare.
    // ------------------------------------------------------------------
    logic [XLEN:0]   rem_sh;
    logic            div_ge;
    logic [XLEN-1:0] div_rem_nx;
    logic [DW-1:0]   div_acc_nx;
    logic [XLEN-1:0] div_a_nx;

    assign rem_sh     = {acc_q[DW-1:XLEN], a_q[XLEN-1]};
    assign div_ge     = (rem_sh >= {1'b0, b_q});
    // When the subtraction is taken the true difference is < divisor, so the
    // low XLEN bits of the difference are exact.
    assign div_rem_nx = div_ge ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
    assign div_acc_nx = {div_rem_nx, acc_q[XLEN-1:0]};
    assign div_a_nx   = {a_q[XLEN-2:0], div_ge};

    logic [DW-1:0]   iter_acc;
    logic [XLEN-1:0] iter_a;

    assign iter_acc = op_q[2] ? div_acc_nx : mul_acc_nx;
    assign iter_a   = op_q[2] ? div_a_nx   : mul_a_nx;

    // ------------------------------------------------------------------
    // Result selection from the final iteration's values
    // ------------------------------------------------------------------
    logic            res_neg;
    logic [DW-1:0]   prod_s;
    logic [XLEN-1:0] quo_s;
    logic [XLEN-1:0] rem_u;
    logic [XLEN-1:0] rem_s;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] fin_result;

    assign res_neg  = s1neg_q ^ s2neg_q;
    assign prod_s   = res_neg ? ({DW{1'b0}} - iter_acc) : iter_acc;
    assign quo_s    = res_neg ? ({XLEN{1'b0}} - iter_a) : iter_a;
    assign rem_u    = iter_acc[DW-1:XLEN];
    assign rem_s    = s1neg_q ? ({XLEN{1'b0}} - rem_u) : rem_u;
    assign div_zero = (b_q == {XLEN{1'b0}});
    // Both sign flags are only set for signed ops; divisor magnitude 1 with a
    // negative sign means rs2 = -1.
    assign div_ovf  = s1neg_q && s2neg_q && (src1_q == MIN_NEG) && (b_q == ONE);

    always_comb begin
        fin_result = {XLEN{1'b0}};
        case (op_q)
            OP_MUL:    fin_result = prod_s[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  fin_result = prod_s[DW-1:XLEN];
            OP_DIV:    fin_result = div_zero ? {XLEN{1'b1}} : (div_ovf ? MIN_NEG : quo_s);
            OP_DIVU:   fin_result = div_zero ? {XLEN{1'b1}} : iter_a;
            OP_REM:    fin_result = div_zero ? src1_q : (div_ovf ? {XLEN{1'b0}} : rem_s);
            OP_REMU:   fin_result = div_zero ? src1_q : rem_u;
            default:   fin_result = {XLEN{1'b0}};
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        src1_d   = src1_q;
        s1neg_d  = s1neg_q;
        s2neg_d  = s2neg_q;
        result_d = result_q;

        if (ctrl_bubble) begin
            // Flush wins everywhere: abandon the op, keep the last result.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (muldiv_valid_i && ctrl_run) begin
                        state_d = S_BUSY;
                        cnt_d   = 5'd0;
                        op_d    = muldiv_op_i;
                        acc_d   = {DW{1'b0}};
                        a_d     = mag1_in;
                        b_d     = mag2_in;
                        src1_d  = muldiv_src1_i;
                        s1neg_d = neg1_in;
                        s2neg_d = neg2_in;
                    end
                end
                S_BUSY: begin
                    if (!ctrl_block) begin
                        acc_d = iter_acc;
                        a_d   = iter_a;
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == LAST_ITER) begin
                            state_d  = S_DONE;
                            result_d = fin_result;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    // Leaving only to IDLE keeps the still-present instruction
                    // from being restarted in this cycle.
                    if (!ctrl_block) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            acc_q    <= {DW{1'b0}};
            a_q      <= {XLEN{1'b0}};
            b_q      <= {XLEN{1'b0}};
            src1_q   <= {XLEN{1'b0}};
            s1neg_q  <= 1'b0;
            s2neg_q  <= 1'b0;
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            src1_q   <= src1_d;
            s1neg_q  <= s1neg_d;
            s2neg_q  <= s2neg_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ex_block_flag_o = ((state_q == S_IDLE) && muldiv_valid_i) || (state_q == S_BUSY);
    assign muldiv_ready_o  = (state_q == S_DONE);
    assign muldiv_result_o = result_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: behavioural timeline/arith model plus hand-computed literals.
module tb_muldiv;

    localparam logic [1:0] C_DEF = 2'd0;
    localparam logic [1:0] C_BLK = 2'd1;
    localparam logic [1:0] C_BUB = 2'd2;
    localparam logic [1:0] C_BRN = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ctrl;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] result;
    logic        flag;
    logic        ready;

    always #5 clk = ~clk;

    muldiv #(.XLEN(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ctrl_signal_muldiv_i (ctrl),
        .muldiv_valid_i       (valid),
        .muldiv_op_i          (op),
        .muldiv_src1_i        (s1),
        .muldiv_src2_i        (s2),
        .muldiv_result_o      (result),
        .ex_block_flag_o      (flag),
        .muldiv_ready_o       (ready)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result of an RV32M op, from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        logic [63:0] pu;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r  = 32'd0;
        case (o)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Timeline model: m_age counts advancing cycles since the start cycle.
    // 1..32 busy, 33 completion, 34 holding the result.
    bit          m_active = 1'b0;
    int          m_age    = 0;
    logic [31:0] m_pend   = 32'd0;
    logic [31:0] m_res    = 32'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_res    <= 32'd0;
        end else if (ctrl == C_BUB) begin
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (valid && ctrl != C_BLK) begin
                m_active <= 1'b1;
                m_age    <= 1;
                m_pend   <= ref_res(op, s1, s2);
            end
        end else if (m_age <= 32) begin
            if (ctrl != C_BLK) begin
                m_age <= m_age + 1;
                if (m_age == 32) m_res <= m_pend;
            end
        end else if (m_age == 33) begin
            m_age <= 34;
        end else if (ctrl != C_BLK) begin
            m_active <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_flag",   {31'd0, flag},  {31'd0, m_active ? (m_age <= 32) : valid});
            chk("model_ready",  {31'd0, ready}, {31'd0, m_active && (m_age == 33)});
            chk("model_result", result, m_res);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Starts an op in the current cycle T, optionally blocks nblk cycles from
    // T+5 and hblk cycles in HOLD, then returns in the first cycle after HOLD.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit, input logic [1:0] runc,
                          input int nblk, input int hblk);
        int k;
        bit got;
        valid = 1'b1;
        op    = o;
        s1    = a;
        s2    = b;
        ctrl  = runc;
        chk({name, "_ref"}, ref_res(o, a, b), lit);
        k   = 0;
        got = 1'b0;
        while (!got && k < 80) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
            end else begin
                step();
                k++;
                ctrl = (k >= 5 && k < 5 + nblk) ? C_BLK : runc;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: no ready within %0d cycles, expected at %0d", name, k, 33 + nblk);
        end else begin
            chk({name, "_latency"}, k, 33 + nblk);
            chk({name, "_result"}, result, lit);
        end
        step();
        for (int i = 0; i < hblk; i++) begin
            ctrl = C_BLK;
            @(negedge clk);
            chk({name, "_hold_result"}, result, lit);
            chk({name, "_hold_ready"}, {31'd0, ready}, 32'd0);
            chk({name, "_hold_flag"}, {31'd0, flag}, 32'd0);
            step();
        end
        ctrl = runc;
        step();
    endtask

    task automatic count_ready(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ready) n++;
            step();
        end
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        valid = 1'b0;
        ctrl  = C_DEF;
        op    = 3'd0;
        s1    = 32'd0;
        s2    = 32'd0;
        step();
        step();
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_result", result, 32'd0);
        chk("reset_flag",   {31'd0, flag},  32'd0);
        chk("reset_ready",  {31'd0, ready}, 32'd0);
        step();

        // Back-to-back ops: each run_op returns in the cycle after HOLD.
        run_op("mul_7xm3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, C_DEF, 0, 0);
        run_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, C_BRN, 0, 0);
        run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, C_DEF, 2, 0);
        run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, C_DEF, 0, 0);
        run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, C_DEF, 0, 0);
        run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, C_DEF, 0, 0);
        run_op("divu_by0",     3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, C_DEF, 0, 0);
        run_op("remu_by0",     3'd7, 32'd100,        32'd0,         32'd100,       C_DEF, 0, 0);
        run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, C_DEF, 0, 0);
        run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         C_DEF, 0, 0);
        run_op("div_neg_by0",  3'd4, 32'hFFFF_FF9C,  32'd0,         32'hFFFF_FFFF, C_DEF, 0, 0);
        run_op("rem_neg_by0",  3'd6, 32'hFFFF_FF9C,  32'd0,         32'hFFFF_FF9C, C_DEF, 0, 0);
        run_op("mul_wrap",     3'd0, 32'h0001_0000,  32'h0001_0000, 32'd0,         C_BRN, 0, 0);
        run_op("mulh_m1x5",    3'd1, 32'hFFFF_FFFF,  32'd5,         32'hFFFF_FFFF, C_DEF, 0, 0);
        run_op("remu_1000_7",  3'd7, 32'd1000,       32'd7,         32'd6,         C_DEF, 0, 0);

        // Block in HOLD for 3 cycles with valid still high: no restart, result stable.
        run_op("divu_1000_7",  3'd5, 32'd1000,       32'd7,         32'd142,       C_DEF, 0, 3);
        // Now in IDLE: a valid op under Block must raise the flag but not start.
        ctrl = C_BLK;
        @(negedge clk);
        chk("idle_block_flag",  {31'd0, flag},  32'd1);
        step();
        @(negedge clk);
        chk("idle_block_flag2", {31'd0, flag},  32'd1);
        chk("idle_block_ready", {31'd0, ready}, 32'd0);
        step();
        valid = 1'b0;
        ctrl  = C_DEF;
        step();

        // Flush at T+10.
        valid = 1'b1;
        op    = 3'd4;
        s1    = 32'd12345;
        s2    = 32'd11;
        ctrl  = C_DEF;
        for (int i = 0; i < 10; i++) step();
        ctrl  = C_BUB;
        valid = 1'b0;
        step();
        ctrl = C_DEF;
        @(negedge clk);
        chk("flush_flag",   {31'd0, flag}, 32'd0);
        chk("flush_result", result, 32'd142);
        count_ready(40, n);
        chk("flush_no_ready", n, 32'd0);
        run_op("after_flush",  3'd4, 32'd12345,      32'd11,        32'd1122,      C_DEF, 0, 0);

        // Reset at T+20.
        valid = 1'b1;
        op    = 3'd0;
        s1    = 32'd9;
        s2    = 32'd9;
        for (int i = 0; i < 20; i++) step();
        rst   = 1'b1;
        valid = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_flag",   {31'd0, flag},  32'd0);
        chk("rst_mid_ready",  {31'd0, ready}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        count_ready(40, n);
        chk("rst_no_ready", n, 32'd0);
        run_op("mul_3x5",      3'd0, 32'd3,          32'd5,         32'd15,        C_DEF, 0, 0);
        valid = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv.md
# muldiv

Iterative RV32M multiply/divide unit in the EX stage, and the responder side of the pipeline controller's EX-block handshake. It accepts one M-extension op from ID/EX and raises `ex_block_flag_o` to stall the pipeline. It then runs a fixed 32-iteration shift-add or restoring-divide sequence under `ctrl_signal_muldiv_i` and pulses `muldiv_ready_o` when the result is valid. The result is held until EX/MEM captures it.

## Interface
- `XLEN`, 32: operand/result width; only 32 supported.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ctrl_signal_muldiv_i` input `CTRL_Wire_Bus`: controller command, encoded with the `CTRL_STATE_*` macros from defines.v.
  - Default: run.
  - Block: freeze.
  - Bubble: flush.
  - Branch: treated as Default.
- `muldiv_valid_i` input 1: the instruction in ID/EX is an M-extension op.
- `muldiv_op_i` input 3: funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `muldiv_src1_i` input 32: rs1 value.
- `muldiv_src2_i` input 32: rs2 value.
- `muldiv_result_o` output 32: result, valid in DONE and HOLD.
- `ex_block_flag_o` output 1: combinational stall request to the controller.
- `muldiv_ready_o` output 1: one-cycle completion pulse to the controller.

## Operation
- States: IDLE, BUSY, DONE, HOLD.
- Reset values:
  - state IDLE, iteration counter 0, `muldiv_result_o` 0.
  - `ex_block_flag_o` 0, `muldiv_ready_o` 0.
  - Reset during any state aborts the op with no result.
- IDLE:
  - `ex_block_flag_o` = `muldiv_valid_i`.
  - Start when `muldiv_valid_i`=1 and ctrl is not Block/Bubble. Latch op, load magnitudes, clear the 64-bit accumulator and counter, go to BUSY.
  - Valid with ctrl Block: no start, flag still 1.
- BUSY:
  - `ex_block_flag_o`=1.
  - One iteration per cycle while ctrl is Default or Branch; ctrl Block freezes all registers.
  - After iteration 31 (counter wraps 31→0), go to DONE.
- DONE:
  - `muldiv_ready_o`=1, `ex_block_flag_o`=0, result registered and driven.
  - Go to HOLD unconditionally.
- HOLD:
  - Result held, both flags 0.
  - ctrl Default or Branch: the pipeline advances this cycle; go to IDLE.
  - ctrl Block: stay.
  - The same instruction still present in ID/EX must not restart; restart only from IDLE.
- Bubble (flush) in any state: go to IDLE next cycle, no ready pulse, result unchanged.
- Multiply:
  - Operands are magnitudes. Signed for MULH on both operands; for MULHSU only src1 is signed; MUL and MULHU are unsigned.
  - Radix-2 shift-add into a 64-bit product.
  - Final product is two's-complement negated when the operand signs differ (signed operands only).
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide:
  - Restoring, one quotient bit per iteration, on magnitudes. DIV and REM are signed; DIVU and REMU unsigned.
  - Quotient is negated when signs differ; remainder takes the dividend's sign.
- Special cases override at result selection; latency is unchanged.
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return src1.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM of the same operands returns 0.

## Timing
- Start accepted in cycle T: `ex_block_flag_o`=1 in T, in which the controller enters EX-block.
- BUSY occupies T+1..T+32.
- DONE is T+33: `muldiv_ready_o`=1, result valid.
- HOLD is T+34: the controller returns to Default and EX/MEM captures `muldiv_result_o` at the end of T+34.
- Fixed latency of 34 cycles from start to capture for all 8 ops and all operand values.
- Each Block cycle during BUSY or HOLD extends the sequence by exactly one cycle.
- `muldiv_ready_o` is never high for more than one cycle per op.
- `ex_block_flag_o` is 0 in DONE and HOLD.
- Back-to-back ops: a new start is possible in the cycle after leaving HOLD.

## Test plan
- MUL 7 × 0xFFFFFFFD:
  - `ex_block_flag_o` high at T..T+32.
  - `muldiv_ready_o` high only at T+33.
  - Result 0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Division:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100 / 0 → 0xFFFFFFFF; REMU 100 / 0 → 100.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Block in HOLD:
  - Drive ctrl Block for 3 cycles after DONE: result stays stable, no restart with valid still high.
  - Return to IDLE on the first Default cycle.
- Flush: Bubble at T+10 gives IDLE at T+11, no ready pulse, and a new op starts cleanly.
- Reset: `rst` at T+20 gives IDLE with all outputs 0 next cycle, no ready pulse; a subsequent MUL 3 × 5 → 15 with nominal timing.
